program_counter: RTL and testbench

- Holds the 32-bit program counter of the single-cycle RV32I core and computes the next fetch address every accepted cycle.
- Selects between sequential (PC+4), PC-relative jump/branch (PC+imm) and register-indirect jump ((rs1+imm) with bit 0 cleared).
- Takes its inputs from the control unit opcode (cuOP), the ALU flags (ALUneg, Zero), register file port 1 and the immediate generator.
- Drives the instruction-fetch address.

---
 rtl/cpu_types_pkg.sv | 33 +++
 rtl/program_counter_branch_resolve.sv | 29 ++
 rtl/program_counter.sv | 78 +++++++
 tb/tb_program_counter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared control-unit types and PC constants for the RV32I single-cycle core.
package cpu_types_pkg;

  typedef enum logic [4:0] {
    CU_LUI   = 5'd0,
    CU_AUIPC = 5'd1,
    CU_JAL   = 5'd2,
    CU_JALR  = 5'd3,
    CU_BEQ   = 5'd4,
    CU_BNE   = 5'd5,
    CU_BLT   = 5'd6,
    CU_BGE   = 5'd7,
    CU_BLTU  = 5'd8,
    CU_BGEU  = 5'd9,
    CU_LB    = 5'd10,
    CU_LH    = 5'd11,
    CU_LW    = 5'd12,
    CU_LBU   = 5'd13,
    CU_LHU   = 5'd14,
    CU_SB    = 5'd15,
    CU_SH    = 5'd16,
    CU_SW    = 5'd17,
    CU_ALUI  = 5'd18,
    CU_ALU   = 5'd19
  } cuOPType;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic word_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/program_counter_branch_resolve.sv
// Decodes cuOP and the ALU flags into jump/branch-taken indications.
module branch_resolve
  import cpu_types_pkg::*;
(
  input  cuOPType cuOP,
  input  logic    ALUneg,
  input  logic    Zero,
  output logic    take_branch,
  output logic    is_jal,
  output logic    is_jalr
);

  // Unknown or non-control opcodes fall to the default: sequential flow.
  always_comb begin
    take_branch = 1'b0;
    is_jal      = 1'b0;
    is_jalr     = 1'b0;
    case (cuOP)
      CU_JAL:           is_jal      = 1'b1;
      CU_JALR:          is_jalr     = 1'b1;
      CU_BEQ:           take_branch = Zero;
      CU_BNE:           take_branch = ~Zero;
      CU_BLT, CU_BLTU:  take_branch = ALUneg;
      CU_BGE, CU_BGEU:  take_branch = ~ALUneg | Zero;
      default:          take_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// RV32I program counter with sequential, PC-relative and register-indirect next-PC.
// Optional macro PC_MISALIGN_CHECK_EN adds a misaligned-target output and holds the PC on it.
module program_counter
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nRST,
  input  cuOPType     cuOP,
  input  logic [31:0] rs1Read,
  input  logic [31:0] signExtend,
  input  logic        ALUneg,
  input  logic        Zero,
  input  logic        iready,
`ifdef PC_MISALIGN_CHECK_EN
  output logic        misaligned,
`endif
  output logic [31:0] PCaddr
);

  logic [31:0] r_pc;
  logic [31:0] w_seq_pc;
  logic [31:0] w_rel_pc;
  logic [31:0] w_ind_pc;
  logic [31:0] w_next_pc;
  logic        w_take_branch;
  logic        w_is_jal;
  logic        w_is_jalr;
  logic        w_redirect;
  logic        w_load_en;

  branch_resolve u_branch_resolve (
    .cuOP        (cuOP),
    .ALUneg      (ALUneg),
    .Zero        (Zero),
    .take_branch (w_take_branch),
    .is_jal      (w_is_jal),
    .is_jalr     (w_is_jalr)
  );

  assign w_seq_pc   = r_pc + PC_INC;
  assign w_rel_pc   = r_pc + signExtend;
  assign w_ind_pc   = (rs1Read + signExtend) & 32'hFFFF_FFFE;
  assign w_redirect = w_is_jal | w_is_jalr | w_take_branch;

  always_comb begin
    w_next_pc = w_seq_pc;
    if (w_is_jalr) begin
      w_next_pc = w_ind_pc;
    end else if (w_is_jal || w_take_branch) begin
      w_next_pc = w_rel_pc;
    end else begin
      w_next_pc = w_seq_pc;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  // A misaligned redirect freezes the PC so the trap unit can take over.
  assign misaligned = iready & ~nRST & w_redirect & word_misaligned(w_next_pc);
  assign w_load_en  = iready & ~misaligned;
`else
  assign w_load_en  = iready;
`endif

  always_ff @(posedge clk) begin
    if (nRST) begin
      r_pc <= RESET_ADDR;
    end else if (w_load_en) begin
      r_pc <= w_next_pc;
    end else begin
      r_pc <= r_pc;
    end
  end

  assign PCaddr = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed test plan plus randomized traffic.
module tb_program_counter;
  import cpu_types_pkg::*;

  logic        clk;
  logic        nRST;
  cuOPType     cuOP;
  logic [31:0] rs1Read;
  logic [31:0] signExtend;
  logic        ALUneg;
  logic        Zero;
  logic        iready;
  logic [31:0] PCaddr;
`ifdef PC_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  int unsigned vectors;
  int unsigned errors;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;

  program_counter #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .cuOP       (cuOP),
    .rs1Read    (rs1Read),
    .signExtend (signExtend),
    .ALUneg     (ALUneg),
    .Zero       (Zero),
    .iready     (iready),
`ifdef PC_MISALIGN_CHECK_EN
    .misaligned (misaligned),
`endif
    .PCaddr     (PCaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what the next PC should be, straight from the ISA rules.
  function automatic logic [31:0] model_next(
    input logic [31:0] pc, input cuOPType op, input logic [31:0] rs1,
    input logic [31:0] imm, input logic neg, input logic z,
    input logic rdy, input logic rst);
    logic        redirect;
    logic [31:0] target;
    if (rst) return 32'h0000_0000;
    if (!rdy) return pc;
    redirect = 1'b0;
    target   = pc + imm;
    if (op == CU_JAL) redirect = 1'b1;
    else if (op == CU_JALR) begin
      redirect = 1'b1;
      target   = rs1 + imm;
      if (target % 2 == 1) target = target - 32'd1;
    end
    else if (op == CU_BEQ) redirect = (z == 1'b1);
    else if (op == CU_BNE) redirect = (z == 1'b0);
    else if (op == CU_BLT || op == CU_BLTU) redirect = (neg == 1'b1);
    else if (op == CU_BGE || op == CU_BGEU) redirect = (neg == 1'b0) || (z == 1'b1);
    if (!redirect) return pc + 32'd4;
`ifdef PC_MISALIGN_CHECK_EN
    if (target % 4 != 0) return pc;
`endif
    return target;
  endfunction

  task automatic step(input logic rst, input cuOPType op, input logic [31:0] rs1,
                      input logic [31:0] imm, input logic neg, input logic z,
                      input logic rdy);
    logic [31:0] e;
    @(negedge clk);
    nRST = rst; cuOP = op; rs1Read = rs1; signExtend = imm;
    ALUneg = neg; Zero = z; iready = rdy;
    e = model_next(model_pc, op, rs1, imm, neg, z, rdy, rst);
    model_pc = e;
    exp_q.push_back(e);
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    step(1'b0, CU_JALR, addr, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: PCaddr is presented after every edge; compare against the oldest expectation.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (PCaddr !== e) begin
          errors++;
          $display("FAIL pcaddr vec=%0d got=%h expected=%h", vectors, PCaddr, e);
        end
      end
    end
  end

  typedef struct { cuOPType op; logic neg; logic z; } br_t;

  initial begin
    br_t br_tab[11];
    cuOPType op;
    logic [31:0] imm, rs1;
    int wait_cycles;
    vectors = 0; errors = 0; model_pc = 32'h0;
    nRST = 1'b1; cuOP = CU_LUI; rs1Read = 32'd0; signExtend = 32'd0;
    ALUneg = 1'b0; Zero = 1'b0; iready = 1'b0;

    // Reset with a pending JAL, then sequential flow.
    repeat (2) step(1'b1, CU_JAL, 32'd0, 32'd100, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, CU_LUI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    goto_pc(32'd8);
    step(1'b0, CU_JAL, 32'd0, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b1);
    step(1'b0, CU_JAL, 32'd0, 32'd20, 1'b0, 1'b0, 1'b1);
    step(1'b0, CU_JALR, 32'd101, 32'd6, 1'b0, 1'b0, 1'b1);
    step(1'b0, CU_JALR, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1);

    br_tab[0]  = '{CU_BEQ,  1'b0, 1'b1};
    br_tab[1]  = '{CU_BNE,  1'b0, 1'b0};
    br_tab[2]  = '{CU_BLT,  1'b1, 1'b0};
    br_tab[3]  = '{CU_BLTU, 1'b1, 1'b0};
    br_tab[4]  = '{CU_BGE,  1'b0, 1'b0};
    br_tab[5]  = '{CU_BGE,  1'b1, 1'b1};
    br_tab[6]  = '{CU_BGEU, 1'b1, 1'b1};
    br_tab[7]  = '{CU_BEQ,  1'b0, 1'b0};
    br_tab[8]  = '{CU_BNE,  1'b0, 1'b1};
    br_tab[9]  = '{CU_BLT,  1'b0, 1'b1};
    br_tab[10] = '{CU_BGEU, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      goto_pc(32'd16);
      step(1'b0, br_tab[i].op, 32'd0, 32'd12, br_tab[i].neg, br_tab[i].z, 1'b1);
    end

    goto_pc(32'd40);
    repeat (3) step(1'b0, CU_JAL, 32'd0, 32'd8, 1'b0, 1'b0, 1'b0);
    step(1'b0, CU_JAL, 32'd0, 32'd8, 1'b0, 1'b0, 1'b1);

    goto_pc(32'hFFFF_FFFC);
    step(1'b0, CU_LUI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    goto_pc(32'd200);
    step(1'b1, CU_JAL, 32'd0, 32'd64, 1'b0, 1'b0, 1'b1);

    // Randomized traffic, including out-of-range opcodes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      op  = cuOPType'(5'($urandom_range(0, 21)));
      imm = $urandom;
      rs1 = $urandom;
      if ($urandom_range(0, 7) != 0) imm = imm & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) != 0) rs1 = rs1 & 32'hFFFF_FFFC;
      step(($urandom_range(0, 31) == 0), op, rs1, imm,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) != 0));
    end

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
